caliptra_ext_mem_loader: RTL and testbench
==========================================

Name: caliptra_ext_mem_loader

Overview:
- Parametrised backdoor loader for the verilated harness. It replaces the single hard-wired external IMEM write port and the static mailbox bit-flip XOR with one generic block.
- The C++ harness pushes (channel, address, data, flip-mask) write requests through a valid/ready port. The requests are buffered in a FIFO.
- Each buffered write is injected into one of NUM_CH SRAM ports (IMEM, mailbox, DCCM, …) only in cycles where the DUT is not using that port. DUT traffic always wins.
- Sits between caliptra_top SRAM ports and the caliptra_sram instances.

Parameters:
- NUM_CH, 3, number of SRAM channels served
- DATA_W, 64, SRAM data width (narrower SRAMs use the LSBs)
- ADDR_W, 15, SRAM address width (narrower SRAMs use the LSBs)
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
- STALL_LIMIT, 16, consecutive blocked cycles before the starvation flag is set
- CH_W, $clog2(NUM_CH) (min 1), channel-select width (derived)

Ports:
- clk  in  1  core clock
- cptra_rst_b  in  1  asynchronous active-low reset
- ext_valid  in  1  harness write request valid
- ext_ready  out  1  request accepted when ext_valid && ext_ready at a clk edge
- ext_ch  in  CH_W  target channel
- ext_addr  in  ADDR_W  word address
- ext_wdata  in  DATA_W  write data
- ext_flip  in  DATA_W  XOR mask applied to ext_wdata when the write is issued (error injection)
- ext_flush  in  1  synchronous drop of all queued requests
- dut_cs_i  in  NUM_CH  DUT chip select per channel
- dut_we_i  in  NUM_CH  DUT write enable per channel
- dut_addr_i  in  NUM_CH*ADDR_W  DUT address, channel c at [c*ADDR_W +: ADDR_W]
- dut_wdata_i  in  NUM_CH*DATA_W  DUT write data, same packing
- mem_cs_o  out  NUM_CH  to SRAM
- mem_we_o  out  NUM_CH  to SRAM
- mem_addr_o  out  NUM_CH*ADDR_W  to SRAM
- mem_wdata_o  out  NUM_CH*DATA_W  to SRAM
- idle_o  out  1  FIFO empty
- wr_count_o  out  32  loader writes issued, saturating at 0xFFFF_FFFF
- starve_o  out  1  sticky: head request blocked for ≥STALL_LIMIT consecutive cycles
- bad_ch_o  out  1  sticky: a request with ext_ch ≥ NUM_CH was accepted

Behaviour:
- Reset (async assert, sync release):
  - FIFO is emptied and counters are cleared.
  - ext_ready=1, idle_o=1, wr_count_o=0, starve_o=0, bad_ch_o=0.
  - mem_* is pure DUT pass-through.
- FIFO:
  - ext_ready = !full. A push when full is impossible: ext_ready already reflects full even if a pop happens in the same cycle.
  - A push and a pop in the same cycle are both allowed when not full.
  - Pointers wrap modulo FIFO_DEPTH; count is ADDR-independent.
- Issue:
  - The head entry (channel h) issues in any cycle where the FIFO is non-empty and dut_cs_i[h]==0.
  - On issue, mem_cs_o[h]=1, mem_we_o[h]=1, mem_addr_o=head addr, mem_wdata_o=head wdata ^ head flip. The entry pops at that clk edge.
  - At most one loader write per cycle across all channels. Strict in-order issue: the head blocks entries behind it, even for free channels.
- Pass-through:
  - For every channel not being written by the loader, mem_*_o = dut_*_i (combinational).
  - dut_cs_i[h]==1 always takes precedence; the loader never overrides a DUT access.
- Latency: a request accepted at edge N is visible on mem_* at the earliest in cycle N+1 (combinational from FIFO head).
- Bad channel: an entry with ch ≥ NUM_CH pops in the cycle it reaches the head with no mem_* activity. It sets bad_ch_o and does not increment wr_count_o.
- Starvation:
  - The blocked counter increments each cycle the head is valid but blocked. It resets to 0 on pop, on flush, or when the FIFO is empty.
  - When the counter reaches STALL_LIMIT, starve_o sets and stays set until reset. The counter saturates.
- Flush:
  - ext_flush=1 empties the FIFO at the next edge. Any push or issue in that cycle is discarded; mem_* stays pass-through that cycle.
  - Counters and sticky flags are kept.
- wr_count_o increments by 1 per issued loader write and holds at the max value.
- Reset mid-operation: queued writes are lost. No partial write is emitted because mem_* is combinational from registered state, which is cleared immediately.

Test Plan:
- Reset, then push ch0 addr 0x10 data 0xDEAD_BEEF_0123_4567 flip 0 with dut_cs_i=0 → next cycle mem_cs_o[0]=mem_we_o[0]=1, addr 0x10, that data; wr_count_o=1; idle_o=1 after.
- Hold dut_cs_i[1]=1 and push 5 requests to ch1 with FIFO_DEPTH=4 → ext_ready=0 after 4 accepts. No ch1 loader writes; DUT signals pass through unchanged. starve_o=1 after 16 blocked cycles. Drop cs → 4 writes in 4 consecutive cycles, in order.
- Push ch2 data 0x0, flip 0x1 → mem_wdata_o ch2 = 0x1 for one cycle; ch0/ch1 pass through DUT values in the same cycle.
- Queue [ch0 (blocked), ch1 (free)] → ch1 write waits until the ch0 write issues (in-order); wr_count_o ends at 2.
- Push ext_ch=3 with NUM_CH=3 → no mem_cs_o activity, bad_ch_o=1, wr_count_o unchanged.
- Queue 3 entries, assert ext_flush one cycle → idle_o=1, no writes issued. Then assert cptra_rst_b=0 mid-queue → all outputs take reset values immediately.

Source files
------------

// File: rtl/caliptra_ext_mem_loader.sv
// Backdoor SRAM loader: queues harness write requests and slips them into
// per-channel SRAM ports in cycles where the DUT leaves that port idle.
module caliptra_ext_mem_loader #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     cptra_rst_b,
    input  logic                     ext_valid,
    output logic                     ext_ready,
    input  logic [CH_W-1:0]          ext_ch,
    input  logic [ADDR_W-1:0]        ext_addr,
    input  logic [DATA_W-1:0]        ext_wdata,
    input  logic [DATA_W-1:0]        ext_flip,
    input  logic                     ext_flush,
    input  logic [NUM_CH-1:0]        dut_cs_i,
    input  logic [NUM_CH-1:0]        dut_we_i,
    input  logic [NUM_CH*ADDR_W-1:0] dut_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] dut_wdata_i,
    output logic [NUM_CH-1:0]        mem_cs_o,
    output logic [NUM_CH-1:0]        mem_we_o,
    output logic [NUM_CH*ADDR_W-1:0] mem_addr_o,
    output logic [NUM_CH*DATA_W-1:0] mem_wdata_o,
    output logic                     idle_o,
    output logic [31:0]              wr_count_o,
    output logic                     starve_o,
    output logic                     bad_ch_o
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [CH_W-1:0]    q_ch    [FIFO_DEPTH];
    logic [ADDR_W-1:0]  q_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0]  q_data  [FIFO_DEPTH];
    logic [DATA_W-1:0]  q_flip  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [STALL_W-1:0] stall_cnt;

    logic              head_valid;
    logic              full;
    logic [CH_W-1:0]   head_ch;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              head_ch_ok;
    logic              head_free;
    logic              issue;
    logic              drop;
    logic              pop;
    logic              push;
    logic              blocked;

    function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
        ch_in_range = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch == CH_W'(c)) ch_in_range = 1'b1;
        end
    endfunction

    // Head decode and issue decision; a flush cancels both push and issue.
    always_comb begin
        head_valid = (count != '0);
        full       = (count == CNT_W'(FIFO_DEPTH));
        head_ch    = q_ch[rd_ptr];
        head_addr  = q_addr[rd_ptr];
        head_wdata = q_data[rd_ptr] ^ q_flip[rd_ptr];
        head_ch_ok = ch_in_range(head_ch);
        head_free  = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (head_ch == CH_W'(c)) head_free = !dut_cs_i[c];
        end
        issue     = head_valid && head_ch_ok && head_free && !ext_flush;
        drop      = head_valid && !head_ch_ok && !ext_flush;
        pop       = issue || drop;
        blocked   = head_valid && head_ch_ok && !head_free;
        ext_ready = !full;
        push      = ext_valid && !full && !ext_flush;
        idle_o    = !head_valid;
    end

    // DUT pass-through with the loader write overlaid on the head's channel.
    always_comb begin
        mem_cs_o    = dut_cs_i;
        mem_we_o    = dut_we_i;
        mem_addr_o  = dut_addr_i;
        mem_wdata_o = dut_wdata_i;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (issue && head_ch == CH_W'(c)) begin
                mem_cs_o[c]                    = 1'b1;
                mem_we_o[c]                    = 1'b1;
                mem_addr_o[c*ADDR_W +: ADDR_W] = head_addr;
                mem_wdata_o[c*DATA_W +: DATA_W] = head_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                q_ch[i]   <= '0;
                q_addr[i] <= '0;
                q_data[i] <= '0;
                q_flip[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stall_cnt  <= '0;
            wr_count_o <= '0;
            starve_o   <= 1'b0;
            bad_ch_o   <= 1'b0;
        end else begin
            if (ext_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    q_ch[wr_ptr]   <= ext_ch;
                    q_addr[wr_ptr] <= ext_addr;
                    q_data[wr_ptr] <= ext_wdata;
                    q_flip[wr_ptr] <= ext_flip;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end

            // Blocked-cycle counter saturates at the limit; flag is sticky.
            if (ext_flush || pop || !head_valid) begin
                stall_cnt <= '0;
            end else if (blocked && stall_cnt != STALL_W'(STALL_LIMIT)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
                if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) starve_o <= 1'b1;
            end

            if (push && !ch_in_range(ext_ch)) bad_ch_o <= 1'b1;
            if (issue && wr_count_o != 32'hFFFF_FFFF) wr_count_o <= wr_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_caliptra_ext_mem_loader.sv
// Directed bench for caliptra_ext_mem_loader: inputs change on the falling
// edge, combinational outputs are sampled 1ns later.
module tb_caliptra_ext_mem_loader;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned CH_W   = 2;

    logic                     clk;
    logic                     cptra_rst_b;
    logic                     ext_valid;
    logic                     ext_ready;
    logic [CH_W-1:0]          ext_ch;
    logic [ADDR_W-1:0]        ext_addr;
    logic [DATA_W-1:0]        ext_wdata;
    logic [DATA_W-1:0]        ext_flip;
    logic                     ext_flush;
    logic [NUM_CH-1:0]        dut_cs_i;
    logic [NUM_CH-1:0]        dut_we_i;
    logic [NUM_CH*ADDR_W-1:0] dut_addr_i;
    logic [NUM_CH*DATA_W-1:0] dut_wdata_i;
    logic [NUM_CH-1:0]        mem_cs_o;
    logic [NUM_CH-1:0]        mem_we_o;
    logic [NUM_CH*ADDR_W-1:0] mem_addr_o;
    logic [NUM_CH*DATA_W-1:0] mem_wdata_o;
    logic                     idle_o;
    logic [31:0]              wr_count_o;
    logic                     starve_o;
    logic                     bad_ch_o;

    int checks = 0;
    int errors = 0;

    caliptra_ext_mem_loader dut (
        .clk         (clk),
        .cptra_rst_b (cptra_rst_b),
        .ext_valid   (ext_valid),
        .ext_ready   (ext_ready),
        .ext_ch      (ext_ch),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_flip    (ext_flip),
        .ext_flush   (ext_flush),
        .dut_cs_i    (dut_cs_i),
        .dut_we_i    (dut_we_i),
        .dut_addr_i  (dut_addr_i),
        .dut_wdata_i (dut_wdata_i),
        .mem_cs_o    (mem_cs_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .idle_o      (idle_o),
        .wr_count_o  (wr_count_o),
        .starve_o    (starve_o),
        .bad_ch_o    (bad_ch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_push(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] flip);
        ext_valid = 1'b1;
        ext_ch    = ch;
        ext_addr  = addr;
        ext_wdata = data;
        ext_flip  = flip;
    endtask

    task automatic clear_push();
        ext_valid = 1'b0;
        ext_ch    = '0;
        ext_addr  = '0;
        ext_wdata = '0;
        ext_flip  = '0;
    endtask

    task automatic test_reset();
        cptra_rst_b = 1'b0;
        clear_push();
        ext_flush   = 1'b0;
        dut_cs_i    = 3'b101;
        dut_we_i    = 3'b001;
        dut_addr_i  = '0;
        dut_wdata_i = '0;
        @(negedge clk); #1;
        checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ext_ready); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle_o); end
        checks++; if (wr_count_o !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", wr_count_o); end
        checks++; if (starve_o !== 1'b0 || bad_ch_o !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", starve_o, bad_ch_o); end
        checks++; if (mem_cs_o !== 3'b101 || mem_we_o !== 3'b001) begin errors++; $display("FAIL rst_pass got %b/%b exp 101/001", mem_cs_o, mem_we_o); end
        cptra_rst_b = 1'b1;
        dut_cs_i = '0;
        dut_we_i = '0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        drive_push(2'd0, 15'h10, 64'hDEAD_BEEF_0123_4567, 64'h0);
        #1;
        checks++; if (mem_cs_o !== 3'b000) begin errors++; $display("FAIL single_early got %b exp 000", mem_cs_o); end
        @(negedge clk);
        clear_push();
        #1;
        checks++; if (mem_cs_o !== 3'b001 || mem_we_o !== 3'b001) begin errors++; $display("FAIL single_cs got %b/%b exp 001/001", mem_cs_o, mem_we_o); end
        checks++; if (mem_addr_o[0 +: ADDR_W] !== 15'h10) begin errors++; $display("FAIL single_addr got %h exp 0010", mem_addr_o[0 +: ADDR_W]); end
        checks++; if (mem_wdata_o[0 +: DATA_W] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL single_data got %h exp deadbeef01234567", mem_wdata_o[0 +: DATA_W]); end
        checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", idle_o); end
        @(negedge clk); #1;
        checks++; if (wr_count_o !== 32'd1) begin errors++; $display("FAIL single_count got %0d exp 1", wr_count_o); end
        checks++; if (idle_o !== 1'b1 || mem_cs_o !== 3'b000) begin errors++; $display("FAIL single_after got idle %b cs %b exp 1 000", idle_o, mem_cs_o); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        dut_cs_i = 3'b010;
        dut_we_i = 3'b010;
        dut_addr_i[1*ADDR_W +: ADDR_W]  = 15'h55;
        dut_wdata_i[1*DATA_W +: DATA_W] = 64'h1234;
        for (int i = 0; i < 4; i++) begin
            drive_push(2'd1, ADDR_W'(32'h20 + i), DATA_W'(32'h100 + i), 64'h0);
            #1;
            checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL bp_ready%0d got %b exp 1", i, ext_ready); end
            @(negedge clk);
        end
        drive_push(2'd1, 15'h24, 64'h104, 64'h0);
        #1;
        checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", ext_ready); end
        checks++; if (mem_cs_o !== 3'b010 || mem_we_o !== 3'b010) begin errors++; $display("FAIL bp_pass_cs got %b/%b exp 010/010", mem_cs_o, mem_we_o); end
        checks++; if (mem_addr_o[1*ADDR_W +: ADDR_W] !== 15'h55 || mem_wdata_o[1*DATA_W +: DATA_W] !== 64'h1234) begin errors++; $display("FAIL bp_pass_data got %h/%h exp 0055/1234", mem_addr_o[1*ADDR_W +: ADDR_W], mem_wdata_o[1*DATA_W +: DATA_W]); end
        @(negedge clk);
        clear_push();
        repeat (11) @(negedge clk);
        #1;
        checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL bp_starve_early got %b exp 0", starve_o); end
        checks++; if (wr_count_o !== 32'd1) begin errors++; $display("FAIL bp_no_write got %0d exp 1", wr_count_o); end
        @(negedge clk); #1;
        checks++; if (starve_o !== 1'b1) begin errors++; $display("FAIL bp_starve got %b exp 1", starve_o); end
        dut_cs_i = 3'b000;
        dut_we_i = 3'b000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (mem_cs_o !== 3'b010 || mem_we_o !== 3'b010) begin errors++; $display("FAIL bp_drain_cs%0d got %b/%b exp 010/010", i, mem_cs_o, mem_we_o); end
            checks++; if (mem_addr_o[1*ADDR_W +: ADDR_W] !== ADDR_W'(32'h20 + i) || mem_wdata_o[1*DATA_W +: DATA_W] !== DATA_W'(32'h100 + i)) begin errors++; $display("FAIL bp_drain_data%0d got %h/%h exp %h/%h", i, mem_addr_o[1*ADDR_W +: ADDR_W], mem_wdata_o[1*DATA_W +: DATA_W], 32'h20 + i, 32'h100 + i); end
            @(negedge clk);
        end
        #1;
        checks++; if (wr_count_o !== 32'd5 || idle_o !== 1'b1) begin errors++; $display("FAIL bp_done got count %0d idle %b exp 5 1", wr_count_o, idle_o); end
        checks++; if (mem_cs_o !== 3'b000 || starve_o !== 1'b1) begin errors++; $display("FAIL bp_sticky got cs %b starve %b exp 000 1", mem_cs_o, starve_o); end
        @(negedge clk);
    endtask

    task automatic test_flip();
        dut_addr_i[0*ADDR_W +: ADDR_W]  = 15'h11;
        dut_addr_i[1*ADDR_W +: ADDR_W]  = 15'h22;
        dut_wdata_i[0*DATA_W +: DATA_W] = 64'hAA;
        dut_wdata_i[1*DATA_W +: DATA_W] = 64'hBB;
        dut_wdata_i[2*DATA_W +: DATA_W] = 64'hCC;
        drive_push(2'd2, 15'h7, 64'h0, 64'h1);
        @(negedge clk);
        clear_push();
        #1;
        checks++; if (mem_cs_o !== 3'b100 || mem_we_o !== 3'b100) begin errors++; $display("FAIL flip_cs got %b/%b exp 100/100", mem_cs_o, mem_we_o); end
        checks++; if (mem_wdata_o[2*DATA_W +: DATA_W] !== 64'h1 || mem_addr_o[2*ADDR_W +: ADDR_W] !== 15'h7) begin errors++; $display("FAIL flip_data got %h/%h exp 1/0007", mem_wdata_o[2*DATA_W +: DATA_W], mem_addr_o[2*ADDR_W +: ADDR_W]); end
        checks++; if (mem_addr_o[0 +: ADDR_W] !== 15'h11 || mem_wdata_o[0 +: DATA_W] !== 64'hAA || mem_wdata_o[1*DATA_W +: DATA_W] !== 64'hBB) begin errors++; $display("FAIL flip_pass got %h/%h/%h exp 0011/aa/bb", mem_addr_o[0 +: ADDR_W], mem_wdata_o[0 +: DATA_W], mem_wdata_o[1*DATA_W +: DATA_W]); end
        @(negedge clk); #1;
        checks++; if (mem_cs_o !== 3'b000 || mem_wdata_o[2*DATA_W +: DATA_W] !== 64'hCC) begin errors++; $display("FAIL flip_after got %b/%h exp 000/cc", mem_cs_o, mem_wdata_o[2*DATA_W +: DATA_W]); end
        checks++; if (wr_count_o !== 32'd6) begin errors++; $display("FAIL flip_count got %0d exp 6", wr_count_o); end
        @(negedge clk);
    endtask

    task automatic test_in_order();
        dut_cs_i = 3'b001;
        dut_we_i = 3'b001;
        dut_addr_i[0 +: ADDR_W] = 15'h3;
        drive_push(2'd0, 15'h1, 64'hA0, 64'h0);
        @(negedge clk);
        drive_push(2'd1, 15'h2, 64'hB0, 64'h0);
        @(negedge clk);
        clear_push();
        #1;
        checks++; if (mem_cs_o !== 3'b001 || mem_addr_o[0 +: ADDR_W] !== 15'h3) begin errors++; $display("FAIL order_block got %b/%h exp 001/0003", mem_cs_o, mem_addr_o[0 +: ADDR_W]); end
        @(negedge clk); #1;
        checks++; if (mem_cs_o !== 3'b001 || wr_count_o !== 32'd6) begin errors++; $display("FAIL order_wait got %b/%0d exp 001/6", mem_cs_o, wr_count_o); end
        dut_cs_i = 3'b000;
        dut_we_i = 3'b000;
        #1;
        checks++; if (mem_cs_o !== 3'b001 || mem_addr_o[0 +: ADDR_W] !== 15'h1 || mem_wdata_o[0 +: DATA_W] !== 64'hA0) begin errors++; $display("FAIL order_first got %b/%h/%h exp 001/0001/a0", mem_cs_o, mem_addr_o[0 +: ADDR_W], mem_wdata_o[0 +: DATA_W]); end
        @(negedge clk); #1;
        checks++; if (mem_cs_o !== 3'b010 || mem_addr_o[1*ADDR_W +: ADDR_W] !== 15'h2 || mem_wdata_o[1*DATA_W +: DATA_W] !== 64'hB0) begin errors++; $display("FAIL order_second got %b/%h/%h exp 010/0002/b0", mem_cs_o, mem_addr_o[1*ADDR_W +: ADDR_W], mem_wdata_o[1*DATA_W +: DATA_W]); end
        @(negedge clk); #1;
        checks++; if (wr_count_o !== 32'd8 || idle_o !== 1'b1) begin errors++; $display("FAIL order_count got %0d idle %b exp 8 1", wr_count_o, idle_o); end
        @(negedge clk);
    endtask

    task automatic test_bad_ch();
        drive_push(2'd3, 15'h5, 64'h99, 64'h0);
        @(negedge clk);
        clear_push();
        #1;
        checks++; if (mem_cs_o !== 3'b000 || mem_we_o !== 3'b000) begin errors++; $display("FAIL bad_cs got %b/%b exp 000/000", mem_cs_o, mem_we_o); end
        checks++; if (bad_ch_o !== 1'b1) begin errors++; $display("FAIL bad_flag got %b exp 1", bad_ch_o); end
        @(negedge clk); #1;
        checks++; if (idle_o !== 1'b1 || wr_count_o !== 32'd8) begin errors++; $display("FAIL bad_drop got idle %b count %0d exp 1 8", idle_o, wr_count_o); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        dut_cs_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            drive_push(2'd0, ADDR_W'(32'h40 + i), 64'h5A, 64'h0);
            @(negedge clk);
        end
        clear_push();
        #1;
        checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL flush_queued got %b exp 0", idle_o); end
        ext_flush = 1'b1;
        dut_cs_i  = 3'b000;
        drive_push(2'd1, 15'h77, 64'h77, 64'h0);
        #1;
        checks++; if (mem_cs_o !== 3'b000) begin errors++; $display("FAIL flush_cs got %b exp 000", mem_cs_o); end
        @(negedge clk);
        ext_flush = 1'b0;
        clear_push();
        #1;
        checks++; if (idle_o !== 1'b1 || mem_cs_o !== 3'b000) begin errors++; $display("FAIL flush_empty got idle %b cs %b exp 1 000", idle_o, mem_cs_o); end
        checks++; if (wr_count_o !== 32'd8 || starve_o !== 1'b1 || bad_ch_o !== 1'b1) begin errors++; $display("FAIL flush_kept got %0d %b %b exp 8 1 1", wr_count_o, starve_o, bad_ch_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        dut_cs_i = 3'b010;
        drive_push(2'd1, 15'h9, 64'h9, 64'h0);
        @(negedge clk);
        drive_push(2'd1, 15'hA, 64'hA, 64'h0);
        @(negedge clk);
        clear_push();
        #1;
        checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL mid_queued got %b exp 0", idle_o); end
        cptra_rst_b = 1'b0;
        #1;
        checks++; if (ext_ready !== 1'b1 || idle_o !== 1'b1) begin errors++; $display("FAIL mid_rst_fifo got %b/%b exp 1/1", ext_ready, idle_o); end
        checks++; if (wr_count_o !== 32'd0 || starve_o !== 1'b0 || bad_ch_o !== 1'b0) begin errors++; $display("FAIL mid_rst_regs got %0d %b %b exp 0 0 0", wr_count_o, starve_o, bad_ch_o); end
        checks++; if (mem_cs_o !== 3'b010) begin errors++; $display("FAIL mid_rst_pass got %b exp 010", mem_cs_o); end
        @(negedge clk);
        cptra_rst_b = 1'b1;
        dut_cs_i = 3'b000;
        #1;
        checks++; if (mem_cs_o !== 3'b000) begin errors++; $display("FAIL mid_no_write got %b exp 000", mem_cs_o); end
        @(negedge clk); #1;
        checks++; if (mem_cs_o !== 3'b000 || wr_count_o !== 32'd0 || idle_o !== 1'b1) begin errors++; $display("FAIL mid_after got %b %0d %b exp 000 0 1", mem_cs_o, wr_count_o, idle_o); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_flip();
        test_in_order();
        test_bad_ch();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
